// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM states and opcode predicates for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_MULH   = 3'd1,
    FN_MULHSU = 3'd2,
    FN_MULHU  = 3'd3,
    FN_DIV    = 3'd4,
    FN_DIVU   = 3'd5,
    FN_REM    = 3'd6,
    FN_REMU   = 3'd7
  } muldiv_fn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_signed_a(input muldiv_fn_t fn);
    return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_fn_t fn);
    return (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic is_div(input muldiv_fn_t fn);
    return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
  endfunction

  // High half of the accumulator: product high word, or the remainder for divides.
  function automatic logic returns_high(input muldiv_fn_t fn);
    return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_MULHU) ||
           (fn == FN_REM)  || (fn == FN_REMU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on {hi, lo}.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: add multiplicand on lsb of the multiplier half, then shift right with carry.
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Divide: shift {rem, quo} left by one and trial-subtract the divisor from the remainder.
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (div) begin
      if (trial[WIDTH]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else              acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit with valid/ready on request and result;
// fixed latency of WIDTH+1 edges from acceptance to result_valid.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  muldiv_fn_t       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  muldiv_fn_t         fn_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg_r;
  logic               b_zero_r;
  logic               ovf_r;

  logic               accept;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   dsel;
  logic [WIDTH-1:0]   fix_val;

  assign start_ready = (state == IDLE) || ((state == DONE) && result_ready);
  assign accept      = start_valid && start_ready;

  always_comb begin
    sign_a = is_signed_a(fn) && a[WIDTH-1];
    sign_b = is_signed_b(fn) && b[WIDTH-1];
    mag_a  = sign_a ? -a : a;
    mag_b  = sign_b ? -b : b;
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .acc      (acc),
    .opnd     (opnd_r),
    .div      (is_div(fn_r)),
    .acc_next (acc_next)
  );

  // Sign correction, half selection and the divide special cases.
  always_comb begin
    prod    = neg_r ? -acc : acc;
    dsel    = returns_high(fn_r) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    fix_val = returns_high(fn_r) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    if (is_div(fn_r)) begin
      fix_val = neg_r ? -dsel : dsel;
      if (b_zero_r)   fix_val = returns_high(fn_r) ? a_r : {WIDTH{1'b1}};
      else if (ovf_r) fix_val = returns_high(fn_r) ? {WIDTH{1'b0}} : MIN_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else if (accept) begin
      state        <= RUN;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state        <= DONE;
          result_valid <= 1'b1;
          result       <= fix_val;
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latches and accumulator; control-free data, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fn_r     <= fn;
      a_r      <= a;
      opnd_r   <= is_div(fn) ? mag_b : mag_a;
      acc      <= is_div(fn) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      neg_r    <= (is_div(fn) && returns_high(fn)) ? sign_a : (sign_a ^ sign_b);
      b_zero_r <= (b == '0);
      ovf_r    <= is_div(fn) && is_signed_b(fn) && (a == MIN_VAL) && (b == {WIDTH{1'b1}});
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit: the multi-cycle companion to the single-cycle arithmetic/logic unit, covering the RV32M-style operations.
- Radix-2 datapath; retires one partial product or quotient bit per clock.
- Valid/ready handshakes on both sides, so the pipeline can stall on it.
- Holds the result until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width in bits; ≥4, even.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start_valid  input  1  request present
- start_ready  output  1  unit can accept request this cycle
- fn  input  3  muldiv_fn_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- a  input  WIDTH  operand 1 (multiplicand / dividend)
- b  input  WIDTH  operand 2 (multiplier / divisor)
- result_valid  output  1  result present
- result_ready  input  1  consumer takes result
- result  output  WIDTH  result; held stable while result_valid && !result_ready

Behaviour:
- Reset: sampled on the rising edge while reset_n == 0.
  - State → IDLE; result_valid = 0; result = 0; counter = 0.
  - start_ready = 1 in the first cycle after reset deasserts.
  - A reset during RUN or FIX aborts the operation silently; no result is produced.
- States:
  - IDLE: start_ready = 1. start_valid && start_ready at an edge latches fn/a/b and goes to RUN with counter = 0.
  - RUN: one iteration per edge. After the iteration with counter == WIDTH-1, go to FIX.
  - FIX: one cycle for sign correction and high/low selection, then go to DONE.
  - DONE: result_valid = 1. On result_ready go to IDLE, or go straight to RUN if a new request is accepted in the same cycle.
- start_ready = (state == IDLE) || (state == DONE && result_ready). This allows back-to-back issue with no bubble.
- Latency: result_valid rises exactly WIDTH+1 edges after the accepting edge. Latency is fixed for all fn and operands, including the special cases below.
- Multiply:
  - Operands are converted to magnitudes according to fn: MULH signed×signed, MULHSU signed×unsigned, MUL and MULHU unsigned.
  - Shift-add into a 2·WIDTH product register.
  - FIX negates the product if the signs differ.
  - MUL returns the low WIDTH bits; the MULH variants return the high WIDTH bits.
- Divide:
  - Restoring division on magnitudes; DIV/REM are signed.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases, decided in FIX:
  - b == 0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (a == MIN, b == -1): DIV returns MIN; REM returns 0.
- Inputs a, b and fn are ignored while not accepted. Changing them during RUN has no effect.
- result changes only on entry to DONE, or on reset.

Decomposition:
- In Opcodes_pkg: muldiv_fn_t (3-bit enum, order as listed above).
- In Types_pkg: state enum muldiv_state_t {IDLE, RUN, FIX, DONE}.
- Predicates is_signed_a(fn), is_signed_b(fn), is_div(fn), returns_high(fn) as package functions.
- One sub-module, muldiv_datapath: combinational single-iteration step (shift-add or trial-subtract) on the accumulator/remainder registers.
- The FSM, counter, operand latches and handshake stay in muldiv_unit.

Test Plan:
1. WIDTH=32 multiply: MUL 12345×1000 → 12345000 after exactly 33 edges. MULHU FFFFFFFF×FFFFFFFF → FFFFFFFE. MULH FFFFFFFF×FFFFFFFF (-1×-1) → 00000000. MULHSU FFFFFFFF×FFFFFFFF → FFFFFFFF.
2. WIDTH=32 divide: DIV -20/3 → FFFFFFFA (-6); REM -20/3 → FFFFFFFE (-2); DIVU 20/3 → 6; REMU 20/3 → 2.
3. Special cases: DIV/DIVU x/0 → FFFFFFFF; REM 7/0 → 7; DIV 80000000/FFFFFFFF → 80000000; REM 80000000/FFFFFFFF → 0. Latency is still 33 edges in every case.
4. Handshake:
   - Hold result_ready=0 for 5 cycles in DONE: result stays stable and start_ready=0.
   - Then result_ready=1 with start_valid=1 (MUL 3×4): second result 12 arrives 33 edges later, with no idle cycle between.
5. Reset mid-operation: pull reset_n low at RUN counter=10 for one edge.
   - Next cycle: result_valid=0, start_ready=1.
   - A fresh DIVU 100/7 → 14.
6. WIDTH=8 instance: MULHU FF×FF → FE; DIV 80/FF → 80; latency 9 edges. Randomised sweep of 1000 ops against a reference model with random result_ready backpressure.
